// File: rtl/gate_sweep_ctrl.sv
// Clocked exhaustive sweep of a combinational gate: walks every input vector,
// waits a settle time, samples the gate output and scores it against a latched truth table.
module gate_sweep_ctrl #(
  parameter int NIN    = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**NIN-1:0]    exp_table,
  input  logic                 dut_y,
  output logic [NIN-1:0]       stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 fail_valid,
  output logic [NIN-1:0]       first_fail
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2**NIN-1:0]   table_q, table_d;
  logic [NIN-1:0]      stim_d, first_fail_d;
  logic [ERR_W-1:0]    err_d;
  logic                busy_d, done_d, pass_d, fail_valid_d;
  logic                mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)                         state_d = ST_IDLE;
        else if (cnt_q == CW'(SETTLE - 1)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)           state_d = ST_IDLE;
        else if (stim == '1) state_d = ST_DONE;
        else                 state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; an abort during CHECK skips that vector's compare.
  always_comb begin
    stim_d       = stim;
    cnt_d        = cnt_q;
    table_d      = table_q;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    first_fail_d = first_fail;
    done_d       = done;
    pass_d       = pass;
    mismatch     = (dut_y != table_q[stim]);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stim_d       = '0;
          cnt_d        = '0;
          table_d      = exp_table;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort) stim_d = '0;
        else       cnt_d  = cnt_q + CW'(1);
      end
      ST_CHECK: begin
        if (abort) begin
          stim_d = '0;
        end else begin
          if (mismatch) begin
            if (err_count != '1) err_d = err_count + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              first_fail_d = stim;
            end
          end
          if (stim == '1) begin
            done_d = 1'b1;
            pass_d = !fail_valid && !mismatch;
          end else begin
            stim_d = stim + NIN'(1);
            cnt_d  = '0;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim       <= '0;
      cnt_q      <= '0;
      table_q    <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      stim       <= stim_d;
      cnt_q      <= cnt_d;
      table_q    <= table_d;
      err_count  <= err_d;
      fail_valid <= fail_valid_d;
      first_fail <= first_fail_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two configurations driven by directed and random sweeps,
// scored against a timing/result model built from vector index arithmetic.
module tb_gate_sweep_ctrl;

  localparam int NIN0 = 1, S0 = 2, W0 = 8;
  localparam int NIN1 = 2, S1 = 1, W1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic       abort_v [2];
  logic [3:0] exp_v   [2];
  logic [3:0] act_v   [2];

  logic       y0, y1;
  logic       stim0;
  logic [1:0] stim1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic [7:0] err0;
  logic       err1;
  logic       ff0;
  logic [1:0] ff1;

  // The "gate under test" is whatever truth table act_v holds.
  assign y0 = act_v[0][stim0];
  assign y1 = act_v[1][stim1];

  gate_sweep_ctrl #(.NIN(NIN0), .SETTLE(S0), .ERR_W(W0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .exp_table(exp_v[0][1:0]), .dut_y(y0), .stim(stim0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0), .first_fail(ff0)
  );

  gate_sweep_ctrl #(.NIN(NIN1), .SETTLE(S1), .ERR_W(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .exp_table(exp_v[1]), .dut_y(y1), .stim(stim1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1), .first_fail(ff1)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nin_of(int k);    return (k == 0) ? NIN0 : NIN1; endfunction
  function automatic int settle_of(int k); return (k == 0) ? S0 : S1;     endfunction
  function automatic int errw_of(int k);   return (k == 0) ? W0 : W1;     endfunction

  function automatic logic [31:0] obs_stim(int k); return (k == 0) ? 32'(stim0) : 32'(stim1); endfunction
  function automatic logic [31:0] obs_busy(int k); return (k == 0) ? 32'(busy0) : 32'(busy1); endfunction
  function automatic logic [31:0] obs_done(int k); return (k == 0) ? 32'(done0) : 32'(done1); endfunction
  function automatic logic [31:0] obs_pass(int k); return (k == 0) ? 32'(pass0) : 32'(pass1); endfunction
  function automatic logic [31:0] obs_err(int k);  return (k == 0) ? 32'(err0)  : 32'(err1);  endfunction
  function automatic logic [31:0] obs_fv(int k);   return (k == 0) ? 32'(fv0)   : 32'(fv1);   endfunction
  function automatic logic [31:0] obs_ff(int k);   return (k == 0) ? 32'(ff0)   : 32'(ff1);   endfunction

  // Vector v is scored at edge (v+1)*(SETTLE+1) after start; count those scored before edge_lim.
  function automatic int model_errs(int k, logic [3:0] e, logic [3:0] a, int edge_lim);
    int sp  = settle_of(k) + 1;
    int cap = (1 << errw_of(k)) - 1;
    int cnt = 0;
    for (int v = 0; v < (1 << nin_of(k)); v++)
      if ((v + 1) * sp < edge_lim && e[v] != a[v]) cnt++;
    return (cnt > cap) ? cap : cnt;
  endfunction

  function automatic int model_first(int k, logic [3:0] e, logic [3:0] a, int edge_lim);
    int sp = settle_of(k) + 1;
    for (int v = 0; v < (1 << nin_of(k)); v++)
      if ((v + 1) * sp < edge_lim && e[v] != a[v]) return v;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, ":stim"}, obs_stim(k), 0);
      checkOutput({tag, ":busy"}, obs_busy(k), 0);
      checkOutput({tag, ":done"}, obs_done(k), 0);
      checkOutput({tag, ":pass"}, obs_pass(k), 0);
      checkOutput({tag, ":err"},  obs_err(k),  0);
      checkOutput({tag, ":fv"},   obs_fv(k),   0);
      checkOutput({tag, ":ff"},   obs_ff(k),   0);
    end
  endtask

  // One sweep on instance k; optional start re-pulse and abort at a given edge count (0 = none).
  task automatic applyStimulus(input int k, input logic [3:0] e, input logic [3:0] a,
                               input int abort_at, input int restart_at, input string name);
    int n     = 1 << nin_of(k);
    int sp    = settle_of(k) + 1;
    int total = n * sp;
    int nerr, ffv, exp_stim;
    act_v[k]   = a;
    exp_v[k]   = e;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    checkOutput({name, ":stim_first"}, obs_stim(k), 0);
    checkOutput({name, ":busy_first"}, obs_busy(k), 1);
    checkOutput({name, ":err_clr"},    obs_err(k),  0);
    for (int c = 1; c <= total; c++) begin
      start_v[k] = (c == restart_at);
      abort_v[k] = (c == abort_at);
      exp_v[k]   = 4'($urandom);
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      if (c == abort_at) begin
        nerr = model_errs(k, e, a, c);
        ffv  = model_first(k, e, a, c);
        checkOutput({name, ":abort_stim"}, obs_stim(k), 0);
        checkOutput({name, ":abort_busy"}, obs_busy(k), 0);
        checkOutput({name, ":abort_done"}, obs_done(k), 0);
        checkOutput({name, ":abort_pass"}, obs_pass(k), 0);
        checkOutput({name, ":abort_err"},  obs_err(k),  nerr);
        checkOutput({name, ":abort_fv"},   obs_fv(k),   (ffv >= 0) ? 1 : 0);
        checkOutput({name, ":abort_ff"},   obs_ff(k),   (ffv >= 0) ? ffv : 0);
        return;
      end
      exp_stim = (c / sp < n) ? c / sp : n - 1;
      checkOutput({name, ":stim"}, obs_stim(k), exp_stim);
      checkOutput({name, ":busy"}, obs_busy(k), (c < total) ? 1 : 0);
      checkOutput({name, ":done"}, obs_done(k), (c == total) ? 1 : 0);
    end
    nerr = model_errs(k, e, a, total + 1);
    ffv  = model_first(k, e, a, total + 1);
    checkOutput({name, ":pass"}, obs_pass(k), (ffv < 0) ? 1 : 0);
    checkOutput({name, ":err"},  obs_err(k),  nerr);
    checkOutput({name, ":fv"},   obs_fv(k),   (ffv >= 0) ? 1 : 0);
    checkOutput({name, ":ff"},   obs_ff(k),   (ffv >= 0) ? ffv : 0);
    // Abort in DONE is ignored; results and last vector hold.
    abort_v[k] = 1'b1;
    @(posedge clk); #1;
    abort_v[k] = 1'b0;
    checkOutput({name, ":hold_done"}, obs_done(k), 1);
    checkOutput({name, ":hold_stim"}, obs_stim(k), n - 1);
    checkOutput({name, ":hold_err"},  obs_err(k),  nerr);
  endtask

  initial begin
    int k, n, total, ab, rs;
    logic [3:0] e, a;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      exp_v[i]   = 4'h0;
      act_v[i]   = 4'h0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 4'b0001, 4'b0001, 0, 0, "inverter");
    applyStimulus(0, 4'b0001, 4'b0010, 0, 0, "buffer");
    applyStimulus(0, 4'b0001, 4'b0011, 0, 0, "stuck1");
    applyStimulus(0, 4'b0001, 4'b0010, 4, 2, "restart_abort");
    applyStimulus(0, 4'b0001, 4'b0001, 0, 0, "after_abort");
    applyStimulus(1, 4'b1000, 4'b1000, 0, 0, "and2");
    applyStimulus(1, 4'b1000, 4'b1110, 0, 0, "or2_sat");

    // Asynchronous reset mid-settle, away from any clock edge.
    act_v[0]   = 4'b0010;
    exp_v[0]   = 4'b0001;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("post_rst_idle");

    for (int it = 0; it < 24; it++) begin
      k     = $urandom_range(0, 1);
      n     = 1 << nin_of(k);
      total = n * (settle_of(k) + 1);
      e     = 4'($urandom);
      a     = ($urandom_range(0, 2) == 0) ? e : (e ^ 4'($urandom));
      ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : 0;
      rs    = $urandom_range(0, total - 1);
      applyStimulus(k, e, a, ab, rs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
